// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event detector.
//   key_state_e       : detector FSM state, 2-bit encoding
//   LONG_DELAY_27M    : default long-press threshold in cycles (0.5 s at 27 MHz)
//   REPEAT_PERIOD_27M : default auto-repeat period in cycles (0.1 s at 27 MHz)
//   COUNT_W           : width of the press counter
package key_event_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    LONG     = 2'd3
  } key_state_e;

  localparam int unsigned LONG_DELAY_27M    = 32'd13_500_000;
  localparam int unsigned REPEAT_PERIOD_27M = 32'd2_700_000;
  localparam int unsigned COUNT_W           = 8;

endpackage

// File: rtl/key_event_detector_press_counter.sv
// Wrapping press counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one press
//   clr        : synchronous clear; clr together with inc loads 1
//   count      : registered count, wraps at 2^COUNT_W
module press_counter
  import key_event_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= COUNT_W'(inc);
    end else if (inc) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/key_event_detector.sv
// Turns a debounced button level into single-cycle event pulses.
//   clk, g_reset  : clock, asynchronous active-low reset
//   clean         : debounced button level (1 = pressed)
//   count_clr     : synchronous clear of press_count
//   press_pulse   : press accepted
//   release_pulse : button released
//   short_press   : released before the long threshold
//   long_press    : long threshold reached
//   repeat_pulse  : periodic pulse while long-held
//   held          : level, button considered down
//   press_count   : wrapping count of accepted presses
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned LONG_DELAY    = LONG_DELAY_27M,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_27M
) (
  input  logic               clk,
  input  logic               g_reset,
  input  logic               clean,
  input  logic               count_clr,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               short_press,
  output logic               long_press,
  output logic               repeat_pulse,
  output logic               held,
  output logic [COUNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_TERM  =
    CNT_W'((REPEAT_PERIOD == 0) ? 0 : (REPEAT_PERIOD - 1));
  localparam logic             REP_EN    = (REPEAT_PERIOD != 0);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  logic press_d, release_d, short_d, long_d, repeat_d, held_d;

  // State and counter registers
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      state_q <= WAIT_REL;
      hold_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
    end
  end

  // Next state and counter updates
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    case (state_q)
      // A button held through reset must be released before it can count
      WAIT_REL: if (!clean) state_d = IDLE;
      IDLE: begin
        if (clean) begin
          state_d = PRESSED;
          hold_d  = CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!clean) begin
          state_d = IDLE;
        end else if (hold_q == LONG_TERM) begin
          state_d = LONG;
          rep_d   = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      LONG: begin
        if (!clean) begin
          state_d = IDLE;
        end else if (REP_EN) begin
          // With repeat disabled rep_q stays parked at 0
          rep_d = (rep_q == REP_TERM) ? '0 : rep_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_REL;
    endcase
  end

  // Next values of the registered event outputs
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = (state_d == PRESSED) || (state_d == LONG);
    case (state_q)
      IDLE:    press_d = clean;
      PRESSED: begin
        release_d = !clean;
        short_d   = !clean;
        long_d    = clean && (hold_q == LONG_TERM);
      end
      LONG: begin
        release_d = !clean;
        // Release on a repeat edge suppresses the repeat
        repeat_d  = clean && REP_EN && (rep_q == REP_TERM);
      end
      default: ;
    endcase
  end

  // Output pulse registers
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_press   <= short_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

  press_counter u_press_counter (
    .clk   (clk),
    .rst_n (g_reset),
    .inc   (press_d),
    .clr   (count_clr),
    .count (press_count)
  );

endmodule
